vip_frame_difference: RTL and testbench

VIP_FRAME_DIFFERENCE -- requirements
Module: vip_frame_difference

---
 rtl/vip_frame_difference.sv | 201 ++++++++++++++++++++
 tb/tb_vip_frame_difference.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vip_frame_difference.sv
// Frame-difference motion detector.
// Each accepted gray pixel is compared with the co-located pixel of the previous frame,
// which is held in an external buffer. Pixels whose absolute difference exceeds
// DIFF_THRESHOLD are marked as motion, and a bounding box around them is reported once
// per frame.
//
// Handshake: a pixel is accepted when per_frame_vsync, per_frame_href and per_frame_clken
// are all high. mem_rd_en and mem_rd_addr are combinational in the acceptance cycle, and
// mem_rd_data is expected exactly one cycle later. mem_wr_en is a one-cycle write strobe
// with no back-pressure.
module vip_frame_difference #(
  parameter int IMG_HDISP      = 640,
  parameter int IMG_VDISP      = 480,
  parameter int DIFF_THRESHOLD = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        per_frame_vsync,
  input  logic        per_frame_href,
  input  logic        per_frame_clken,
  input  logic [7:0]  per_img_Gray,
  output logic        mem_rd_en,
  output logic [18:0] mem_rd_addr,
  input  logic [7:0]  mem_rd_data,
  output logic        mem_wr_en,
  output logic [18:0] mem_wr_addr,
  output logic [7:0]  mem_wr_data,
  output logic        post_frame_vsync,
  output logic        post_frame_href,
  output logic        post_frame_clken,
  output logic [23:0] post_img_Bin,
  output logic        box_valid,
  output logic        box_hit,
  output logic [9:0]  box_xmin,
  output logic [9:0]  box_xmax,
  output logic [9:0]  box_ymin,
  output logic [9:0]  box_ymax
);

  localparam logic [18:0] PIX_TOTAL = 19'(IMG_HDISP * IMG_VDISP);
  localparam logic [8:0]  THRESH    = 9'(DIFF_THRESHOLD);

  typedef enum logic [1:0] {IDLE = 2'd0, FIRST = 2'd1, RUN = 2'd2} state_t;

  state_t      state;
  state_t      frame_state;
  logic        vsync_q, vsync_low_q, href_q;
  logic        vsync_rise, vsync_fall, href_fall;
  logic        accept, in_range, do_read, do_write;
  logic [18:0] addr, cur_addr;
  logic [9:0]  x_cnt, y_cnt, cur_x, cur_y;
  logic        frame_run;
  logic        s1_wr, s1_rd;
  logic [18:0] s1_addr;
  logic [7:0]  s1_pix;
  logic [9:0]  s1_x, s1_y;
  logic        vs_d1, hs_d1, ce_d1;
  logic [8:0]  diff;
  logic        motion, box_copy;
  logic        run_hit;
  logic [9:0]  run_xmin, run_xmax, run_ymin, run_ymax;

  // vsync_low_q clears on reset, so a frame already in progress when reset is released
  // is never mistaken for a new rising edge.
  assign vsync_rise  = per_frame_vsync & vsync_low_q;
  assign vsync_fall  = ~per_frame_vsync & vsync_q;
  assign href_fall   = ~per_frame_href & href_q;
  assign accept      = rst_n & per_frame_vsync & per_frame_href & per_frame_clken;
  // A pixel arriving on the rising-edge cycle already belongs to the new frame.
  assign cur_addr    = vsync_rise ? 19'd0 : addr;
  assign cur_x       = vsync_rise ? 10'd0 : x_cnt;
  assign cur_y       = vsync_rise ? 10'd0 : y_cnt;
  assign in_range    = cur_addr < PIX_TOTAL;
  assign frame_state = (state == IDLE && vsync_rise) ? FIRST : state;
  assign do_write    = accept & in_range & (frame_state != IDLE);
  assign do_read     = accept & in_range & (frame_state == RUN);
  assign mem_rd_en   = do_read;
  assign mem_rd_addr = cur_addr;

  assign diff     = (s1_pix >= mem_rd_data) ? ({1'b0, s1_pix} - {1'b0, mem_rd_data})
                                            : ({1'b0, mem_rd_data} - {1'b0, s1_pix});
  assign motion   = s1_rd & (diff > THRESH);
  // post_frame_vsync is about to fall, and the frame that is ending was a compared frame.
  assign box_copy = post_frame_vsync & ~vs_d1 & frame_run;

  // Frame-state FSM: the first frame after reset only fills the buffer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (vsync_rise) state <= FIRST;
        FIRST:   if (vsync_fall) state <= RUN;
        RUN:     state <= RUN;
        default: state <= IDLE;
      endcase
    end
  end

  // Edge detectors, pixel address and x/y position counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vsync_q     <= 1'b0;
      vsync_low_q <= 1'b0;
      href_q      <= 1'b0;
      addr        <= '0;
      x_cnt       <= '0;
      y_cnt       <= '0;
      frame_run   <= 1'b0;
    end else begin
      vsync_q     <= per_frame_vsync;
      vsync_low_q <= ~per_frame_vsync;
      href_q      <= per_frame_href;
      if (accept)          addr <= in_range ? cur_addr + 19'd1 : cur_addr;
      else if (vsync_rise) addr <= '0;
      if (accept)                      x_cnt <= cur_x + 10'd1;
      else if (href_fall || vsync_rise) x_cnt <= '0;
      if (vsync_rise)     y_cnt <= '0;
      else if (href_fall) y_cnt <= y_cnt + 10'd1;
      if (vsync_rise) frame_run <= (state == RUN);
    end
  end

  // Stage 1 (write-back) and stage 2 (compare) pipeline with the matching sync delays.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_wr            <= 1'b0;
      s1_rd            <= 1'b0;
      s1_addr          <= '0;
      s1_pix           <= '0;
      s1_x             <= '0;
      s1_y             <= '0;
      vs_d1            <= 1'b0;
      hs_d1            <= 1'b0;
      ce_d1            <= 1'b0;
      post_frame_vsync <= 1'b0;
      post_frame_href  <= 1'b0;
      post_frame_clken <= 1'b0;
      post_img_Bin     <= '0;
      mem_wr_en        <= 1'b0;
      mem_wr_addr      <= '0;
      mem_wr_data      <= '0;
    end else begin
      s1_wr            <= do_write;
      s1_rd            <= do_read;
      s1_addr          <= cur_addr;
      s1_pix           <= per_img_Gray;
      s1_x             <= cur_x;
      s1_y             <= cur_y;
      vs_d1            <= per_frame_vsync;
      hs_d1            <= per_frame_href;
      ce_d1            <= per_frame_clken;
      post_frame_vsync <= vs_d1;
      post_frame_href  <= hs_d1;
      post_frame_clken <= ce_d1;
      post_img_Bin     <= motion ? 24'hFFFFFF : 24'h000000;
      mem_wr_en        <= do_write;
      mem_wr_addr      <= cur_addr;
      mem_wr_data      <= per_img_Gray;
    end
  end

  // Running bounding box over the motion pixels of a compared frame.
  always_ff @(posedge clk) begin
    if (!rst_n || vsync_rise) begin
      run_hit  <= 1'b0;
      run_xmin <= 10'd1023;
      run_xmax <= 10'd0;
      run_ymin <= 10'd1023;
      run_ymax <= 10'd0;
    end else if (motion) begin
      run_hit <= 1'b1;
      if (s1_x < run_xmin) run_xmin <= s1_x;
      if (s1_x > run_xmax) run_xmax <= s1_x;
      if (s1_y < run_ymin) run_ymin <= s1_y;
      if (s1_y > run_ymax) run_ymax <= s1_y;
    end
  end

  // Publish the box once per compared frame and hold it until the next frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      box_valid <= 1'b0;
      box_hit   <= 1'b0;
      box_xmin  <= 10'd1023;
      box_xmax  <= 10'd0;
      box_ymin  <= 10'd1023;
      box_ymax  <= 10'd0;
    end else begin
      box_valid <= box_copy;
      if (box_copy) begin
        box_hit  <= run_hit;
        box_xmin <= run_xmin;
        box_xmax <= run_xmax;
        box_ymin <= run_ymin;
        box_ymax <= run_ymax;
      end
    end
  end

endmodule

// File: tb/tb_vip_frame_difference.sv
// Bench for vip_frame_difference on a 4x2 image with a behavioural frame-buffer model.
module tb_vip_frame_difference;

  localparam int H    = 4;
  localparam int V    = 2;
  localparam int TH   = 30;
  localparam int NPIX = H * V;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        vs = 1'b0, hs = 1'b0, ce = 1'b0;
  logic [7:0]  gray = 8'd0;
  logic        mem_rd_en, mem_wr_en;
  logic [18:0] mem_rd_addr, mem_wr_addr;
  logic [7:0]  mem_rd_data = 8'd0;
  logic [7:0]  mem_wr_data;
  logic        post_frame_vsync, post_frame_href, post_frame_clken;
  logic [23:0] post_img_Bin;
  logic        box_valid, box_hit;
  logic [9:0]  box_xmin, box_xmax, box_ymin, box_ymax;

  vip_frame_difference #(.IMG_HDISP(H), .IMG_VDISP(V), .DIFF_THRESHOLD(TH)) dut (
    .clk(clk), .rst_n(rst_n),
    .per_frame_vsync(vs), .per_frame_href(hs), .per_frame_clken(ce), .per_img_Gray(gray),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .post_frame_vsync(post_frame_vsync), .post_frame_href(post_frame_href),
    .post_frame_clken(post_frame_clken), .post_img_Bin(post_img_Bin),
    .box_valid(box_valid), .box_hit(box_hit),
    .box_xmin(box_xmin), .box_xmax(box_xmax), .box_ymin(box_ymin), .box_ymax(box_ymax)
  );

  // External frame buffer: read data appears one cycle after the strobe.
  logic [7:0] mem [0:15];
  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_wr_addr[3:0]] <= mem_wr_data;
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr[3:0]];
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic        vs, hs, ce;
    logic [23:0] bin;
    logic        wr;
    logic [18:0] wa;
    logic [7:0]  wd;
    int          idx;
    logic        bv, bhit;
    logic [9:0]  bx0, bx1, by0, by1;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int bv_count = 0;
  int wr_count = 0;
  logic [23:0] got_bin [0:8];
  logic [7:0]  f_img   [0:8];

  // Reference model state, in terms of frames and a stored reference image.
  bit   m_seen_low, m_prev_vs, m_prev_hs, m_active, m_compare, m_ref_ok;
  int   m_idx, m_x, m_y, m_xmin, m_xmax, m_ymin, m_ymax;
  bit   m_hit;
  logic [7:0] stored [0:NPIX-1];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic v, input logic h, input logic c, input logic [7:0] p);
    exp_t e, o;
    bit   rise, acc, inr, exp_rd;
    int   a, b, d, rd_idx;
    vs = v; hs = h; ce = c; gray = p;
    e = '{default: '0};
    e.vs = v; e.hs = h; e.ce = c; e.idx = -1;
    rise = v && m_seen_low;
    if (rise) begin
      m_active = 1; m_compare = m_ref_ok;
      m_idx = 0; m_x = 0; m_y = 0;
      m_xmin = 1023; m_xmax = 0; m_ymin = 1023; m_ymax = 0; m_hit = 0;
    end
    acc    = v && h && c && m_active;
    inr    = m_idx < NPIX;
    exp_rd = acc && inr && m_compare;
    rd_idx = m_idx;
    if (acc && inr) begin
      e.wr = 1; e.wa = 19'(m_idx); e.wd = p; e.idx = m_idx;
      if (m_compare) begin
        a = int'(p); b = int'(stored[m_idx]);
        d = (a > b) ? a - b : b - a;
        if (d > TH) begin
          e.bin = 24'hFFFFFF; m_hit = 1;
          if (m_x < m_xmin) m_xmin = m_x;
          if (m_x > m_xmax) m_xmax = m_x;
          if (m_y < m_ymin) m_ymin = m_y;
          if (m_y > m_ymax) m_ymax = m_y;
        end
      end
      stored[m_idx] = p;
    end else if (acc) begin
      e.idx = NPIX;
    end
    #1;
    chk("rd_en", {31'd0, mem_rd_en}, {31'd0, exp_rd});
    if (exp_rd) chk("rd_addr", {13'd0, mem_rd_addr}, rd_idx);
    if (acc) begin
      if (inr) m_idx++;
      m_x++;
    end
    if (!h && m_prev_hs) begin m_x = 0; m_y++; end
    if (!v && m_prev_vs && m_active) begin
      m_active = 0; m_ref_ok = 1;
      if (m_compare) begin
        e.bv = 1; e.bhit = m_hit;
        e.bx0 = 10'(m_xmin); e.bx1 = 10'(m_xmax); e.by0 = 10'(m_ymin); e.by1 = 10'(m_ymax);
      end
    end
    m_seen_low = !v; m_prev_vs = v; m_prev_hs = h;
    exp_q.push_back(e);
    @(posedge clk); #1;
    chk("wr_en", {31'd0, mem_wr_en}, {31'd0, e.wr});
    if (mem_wr_en) wr_count++;
    if (e.wr) begin
      chk("wr_addr", {13'd0, mem_wr_addr}, {13'd0, e.wa});
      chk("wr_data", {24'd0, mem_wr_data}, {24'd0, e.wd});
    end
    if (exp_q.size() == 2) begin
      o = exp_q.pop_front();
      chk("post_vsync", {31'd0, post_frame_vsync}, {31'd0, o.vs});
      chk("post_href",  {31'd0, post_frame_href},  {31'd0, o.hs});
      chk("post_clken", {31'd0, post_frame_clken}, {31'd0, o.ce});
      chk("post_bin",   {8'd0, post_img_Bin},      {8'd0, o.bin});
      chk("box_valid",  {31'd0, box_valid},        {31'd0, o.bv});
      if (box_valid) bv_count++;
      if (o.idx >= 0) got_bin[o.idx] = post_img_Bin;
      if (o.bv) begin
        chk("box_hit",  {31'd0, box_hit},  {31'd0, o.bhit});
        chk("box_xmin", {22'd0, box_xmin}, {22'd0, o.bx0});
        chk("box_xmax", {22'd0, box_xmax}, {22'd0, o.bx1});
        chk("box_ymin", {22'd0, box_ymin}, {22'd0, o.by0});
        chk("box_ymax", {22'd0, box_ymax}, {22'd0, o.by1});
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    m_seen_low = 0; m_prev_vs = 0; m_prev_hs = 0; m_active = 0; m_compare = 0; m_ref_ok = 0;
    #1;
    chk("rst_post_bin",   {8'd0, post_img_Bin}, 32'd0);
    chk("rst_post_vsync", {31'd0, post_frame_vsync}, 32'd0);
    chk("rst_wr_en",      {31'd0, mem_wr_en}, 32'd0);
    chk("rst_rd_en",      {31'd0, mem_rd_en}, 32'd0);
    chk("rst_box_valid",  {31'd0, box_valid}, 32'd0);
    chk("rst_box_hit",    {31'd0, box_hit}, 32'd0);
    chk("rst_box_xmin",   {22'd0, box_xmin}, 32'd1023);
    chk("rst_box_ymin",   {22'd0, box_ymin}, 32'd1023);
    chk("rst_box_xmax",   {22'd0, box_xmax}, 32'd0);
    @(posedge clk); #1;
  endtask

  // One frame from f_img: 'pre' vsync-only cycles, optional extra pixel on the last line,
  // optional random clken gaps inside href.
  task automatic frame(input int pre, input int extra, input bit gaps);
    int k, n, px;
    for (int i = 0; i < 9; i++) got_bin[i] = 24'h123456;
    for (int i = 0; i < pre; i++) step(1, 0, 0, 8'd0);
    k = 0;
    for (int ln = 0; ln < V; ln++) begin
      n = H + ((ln == V - 1) ? extra : 0);
      px = 0;
      while (px < n) begin
        if (gaps && $urandom_range(0, 2) == 0) step(1, 1, 0, 8'($urandom_range(0, 255)));
        else begin step(1, 1, 1, f_img[k]); k++; px++; end
      end
      step(1, 0, 0, 8'd0);
      step(1, 0, 0, 8'd0);
    end
    for (int i = 0; i < 3; i++) step(0, 0, 0, 8'd0);
  endtask

  typedef struct { logic [7:0] prev, cur; logic [23:0] bin; } vec_t;
  vec_t tbl [0:7];

  // ---------------- test sequence ----------------
  initial begin
    int v;
    tbl[0] = '{8'd100, 8'd130, 24'h000000};
    tbl[1] = '{8'd100, 8'd131, 24'hFFFFFF};
    tbl[2] = '{8'd130, 8'd100, 24'h000000};
    tbl[3] = '{8'd131, 8'd100, 24'hFFFFFF};
    tbl[4] = '{8'd255, 8'd0,   24'hFFFFFF};
    tbl[5] = '{8'd0,   8'd255, 24'hFFFFFF};
    tbl[6] = '{8'd200, 8'd200, 24'h000000};
    tbl[7] = '{8'd0,   8'd30,  24'h000000};

    #1;
    do_reset();
    step(0, 0, 0, 8'd0);

    // Two identical flat frames: no motion, exactly one box report.
    for (int i = 0; i < 9; i++) f_img[i] = 8'd100;
    bv_count = 0;
    frame(1, 0, 0);
    frame(1, 0, 0);
    chk("flat_bv_count", bv_count, 1);
    chk("flat_box_hit", {31'd0, box_hit}, 32'd0);
    for (int i = 0; i < NPIX; i++) chk("flat_bin", {8'd0, got_bin[i]}, 32'd0);

    // Single changed pixel at x=2, y=1.
    f_img[6] = 8'd140;
    frame(1, 0, 0);
    chk("one_bin_hit",  {8'd0, got_bin[6]}, 32'hFFFFFF);
    chk("one_bin_miss", {8'd0, got_bin[5]}, 32'd0);
    chk("one_box_hit",  {31'd0, box_hit}, 32'd1);
    chk("one_box_xmin", {22'd0, box_xmin}, 32'd2);
    chk("one_box_xmax", {22'd0, box_xmax}, 32'd2);
    chk("one_box_ymin", {22'd0, box_ymin}, 32'd1);
    chk("one_box_ymax", {22'd0, box_ymax}, 32'd1);

    // Threshold table; the second frame starts with a pixel on the vsync rising edge.
    for (int i = 0; i < NPIX; i++) f_img[i] = tbl[i].prev;
    frame(1, 0, 0);
    for (int i = 0; i < NPIX; i++) f_img[i] = tbl[i].cur;
    frame(0, 0, 0);
    for (int i = 0; i < NPIX; i++) chk($sformatf("tbl_%0d", i), {8'd0, got_bin[i]}, {8'd0, tbl[i].bin});

    // clken gaps inside href: addresses stay contiguous.
    for (int i = 0; i < NPIX; i++) f_img[i] = 8'($urandom_range(0, 255));
    wr_count = 0;
    frame(1, 0, 1);
    chk("gap_wr_count", wr_count, NPIX);

    // Nine pixels into an eight-pixel frame: the ninth is neither read nor written.
    for (int i = 0; i < 9; i++) f_img[i] = 8'($urandom_range(0, 255));
    wr_count = 0;
    frame(1, 1, 0);
    chk("sat_wr_count", wr_count, NPIX);
    chk("sat_bin", {8'd0, got_bin[8]}, 32'd0);

    // Reset in the middle of a frame aborts it; the following frame only refills.
    bv_count = 0;
    step(1, 0, 0, 8'd0);
    for (int i = 0; i < 3; i++) step(1, 1, 1, 8'($urandom_range(0, 255)));
    do_reset();
    step(1, 1, 1, 8'd7);
    step(1, 0, 0, 8'd0); step(1, 0, 0, 8'd0);
    for (int i = 0; i < H; i++) step(1, 1, 1, 8'($urandom_range(0, 255)));
    step(1, 0, 0, 8'd0); step(1, 0, 0, 8'd0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 8'd0);
    chk("abort_bv_count", bv_count, 0);
    for (int i = 0; i < NPIX; i++) f_img[i] = 8'($urandom_range(0, 255));
    frame(1, 0, 0);
    chk("refill_bv_count", bv_count, 0);
    for (int i = 0; i < NPIX; i++) chk("refill_bin", {8'd0, got_bin[i]}, 32'd0);
    for (int i = 0; i < NPIX; i++) f_img[i] = f_img[i] ^ 8'h80;
    frame(1, 0, 0);
    chk("after_bv_count", bv_count, 1);
    for (int i = 0; i < NPIX; i++) chk("after_bin", {8'd0, got_bin[i]}, 32'hFFFFFF);
    chk("after_box_xmin", {22'd0, box_xmin}, 32'd0);
    chk("after_box_xmax", {22'd0, box_xmax}, 32'd3);
    chk("after_box_ymin", {22'd0, box_ymin}, 32'd0);
    chk("after_box_ymax", {22'd0, box_ymax}, 32'd1);

    // Random frames near the threshold against the model.
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < NPIX; i++) begin
        v = int'(stored[i]) + $urandom_range(0, 70) - 35;
        if (v < 0) v = 0;
        if (v > 255) v = 255;
        f_img[i] = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255)) : 8'(v);
      end
      frame($urandom_range(0, 2), 0, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
